// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ctrl_if
//  Purpose  : Bundles the EX/MEM register outputs, the data-memory handshake
//             and the MEM/WB register outputs seen by mem_stage_ctrl.
//  Modports : master - the MEM-stage controller (drives memory request, stall
//                      and the WB_* register outputs)
//             slave  - the surrounding pipeline / memory model
//  Ports    : MEM_MemWrite, MEM_MemRead, MEM_MemtoReg, MEM_RegWrite,
//             MEM_ALUval[15:0], MEM_ReadData2[15:0], MEM_DstReg[3:0],
//             mem_rdata[15:0], mem_data_valid           (into controller)
//             mem_enable, mem_wr, mem_addr[15:0], mem_wdata[15:0], stall,
//             mem_timeout, WB_MemtoReg, WB_RegWrite, WB_ALUval[15:0],
//             WB_MemData[15:0], WB_DstReg[3:0]           (out of controller)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if;
    logic        MEM_MemWrite;
    logic        MEM_MemRead;
    logic        MEM_MemtoReg;
    logic        MEM_RegWrite;
    logic [15:0] MEM_ALUval;
    logic [15:0] MEM_ReadData2;
    logic [3:0]  MEM_DstReg;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        stall;
    logic        mem_timeout;
    logic        WB_MemtoReg;
    logic        WB_RegWrite;
    logic [15:0] WB_ALUval;
    logic [15:0] WB_MemData;
    logic [3:0]  WB_DstReg;

    modport master (
        input  MEM_MemWrite, MEM_MemRead, MEM_MemtoReg, MEM_RegWrite,
               MEM_ALUval, MEM_ReadData2, MEM_DstReg, mem_rdata, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_wdata, stall, mem_timeout,
               WB_MemtoReg, WB_RegWrite, WB_ALUval, WB_MemData, WB_DstReg
    );

    modport slave (
        output MEM_MemWrite, MEM_MemRead, MEM_MemtoReg, MEM_RegWrite,
               MEM_ALUval, MEM_ReadData2, MEM_DstReg, mem_rdata, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_wdata, stall, mem_timeout,
               WB_MemtoReg, WB_RegWrite, WB_ALUval, WB_MemData, WB_DstReg
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ctrl
//  Purpose  : Consumer of the EX/MEM pipeline register. Launches a variable-
//             latency data-memory access, stalls upstream while it is in
//             flight, and loads the MEM/WB register (bubbles while stalled so
//             no instruction writes back twice). A watchdog forces completion
//             after TIMEOUT wait cycles and sets a sticky mem_timeout flag.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - mem_stage_ctrl_if.master (EX/MEM inputs, memory
//                     handshake, stall, MEM/WB register outputs)
//  Params   : TIMEOUT - max WAIT cycles before forced completion (1..255)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_stage_ctrl_if.master   bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        wb_memtoreg_q, wb_memtoreg_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [15:0] wb_aluval_q, wb_aluval_d;
    logic [15:0] wb_memdata_q, wb_memdata_d;
    logic [3:0]  wb_dstreg_q, wb_dstreg_d;
    logic        w_req;

    assign w_req = bus.MEM_MemRead | bus.MEM_MemWrite;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timeout_d      = timeout_q;
        wb_memtoreg_d  = wb_memtoreg_q;
        wb_regwrite_d  = wb_regwrite_q;
        wb_aluval_d    = wb_aluval_q;
        wb_memdata_d   = wb_memdata_q;
        wb_dstreg_d    = wb_dstreg_q;
        bus.mem_enable = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.stall      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    // Launch; a store wins when both read and write are set.
                    bus.mem_enable = 1'b1;
                    bus.mem_wr     = bus.MEM_MemWrite;
                    bus.stall      = 1'b1;
                    wb_regwrite_d  = 1'b0;
                    wb_memtoreg_d  = 1'b0;
                    cnt_d          = 8'd0;
                    state_d        = S_WAIT;
                end else begin
                    // Late/stale mem_data_valid here is deliberately ignored.
                    wb_memtoreg_d = bus.MEM_MemtoReg;
                    wb_regwrite_d = bus.MEM_RegWrite;
                    wb_aluval_d   = bus.MEM_ALUval;
                    wb_memdata_d  = 16'h0000;
                    wb_dstreg_d   = bus.MEM_DstReg;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.mem_data_valid || (cnt_q == c_cnt_last)) begin
                    // Completion cycle: stall drops so EX/MEM advances at this edge.
                    wb_memtoreg_d = bus.MEM_MemtoReg;
                    wb_regwrite_d = bus.MEM_RegWrite;
                    wb_aluval_d   = bus.MEM_ALUval;
                    wb_dstreg_d   = bus.MEM_DstReg;
                    state_d       = S_IDLE;
                    if (bus.mem_data_valid) begin
                        wb_memdata_d = bus.mem_rdata;
                    end else begin
                        wb_memdata_d = 16'h0000;
                        timeout_d    = 1'b1;
                    end
                end else begin
                    bus.stall     = 1'b1;
                    wb_regwrite_d = 1'b0;
                    wb_memtoreg_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            timeout_q     <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_aluval_q   <= 16'h0000;
            wb_memdata_q  <= 16'h0000;
            wb_dstreg_q   <= 4'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_aluval_q   <= wb_aluval_d;
            wb_memdata_q  <= wb_memdata_d;
            wb_dstreg_q   <= wb_dstreg_d;
        end
    end

    // Address/data pass straight through; EX/MEM is frozen during an access.
    assign bus.mem_addr    = bus.MEM_ALUval;
    assign bus.mem_wdata   = bus.MEM_ReadData2;
    assign bus.mem_timeout = timeout_q;
    assign bus.WB_MemtoReg = wb_memtoreg_q;
    assign bus.WB_RegWrite = wb_regwrite_q;
    assign bus.WB_ALUval   = wb_aluval_q;
    assign bus.WB_MemData  = wb_memdata_q;
    assign bus.WB_DstReg   = wb_dstreg_q;

endmodule
`default_nettype wire
